// File: rtl/demux1_4_capture.sv
// Beat-wise 1:4 capture: steers DATA_W-bit beats into four slots and hands out
// completed words through a valid/ack holding register. Optional macro: FRAME_SYNC_EN.
module demux1_4_capture #(
   parameter int DATA_W = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                din_valid,
   input  logic [DATA_W-1:0]   din,
`ifdef FRAME_SYNC_EN
   input  logic                din_sof,
`endif
   output logic [4*DATA_W-1:0] dout,
   output logic                dout_valid,
   input  logic                dout_ack,
   output logic [1:0]          slot,
   output logic                overflow,
   input  logic                clr_ovf
);

   logic                     sof_hit;
   logic [1:0]               slot_q, slot_d, wr_slot;
   logic [3:0][DATA_W-1:0]   asm_q, asm_d, full_word;
   logic [4*DATA_W-1:0]      dout_q, dout_d;
   logic                     dout_valid_q, dout_valid_d;
   logic                     overflow_q, overflow_d;
   logic                     frame_done, drop;

`ifdef FRAME_SYNC_EN
   assign sof_hit = din_valid & din_sof;
`else
   assign sof_hit = 1'b0;
`endif

   // Next-state: slot steering, word completion, holder handshake, sticky overflow
   always_comb begin
      wr_slot      = sof_hit ? 2'd0 : slot_q;
      frame_done   = din_valid & (wr_slot == 2'd3);
      full_word    = asm_q;
      full_word[3] = din;
      slot_d       = slot_q;
      asm_d        = asm_q;
      dout_d       = dout_q;
      dout_valid_d = dout_valid_q;
      overflow_d   = overflow_q;
      drop         = 1'b0;

      if (din_valid) begin
         asm_d[wr_slot] = din;
         slot_d         = wr_slot + 2'd1;
      end else begin
         slot_d = slot_q;
      end

      // A completing word may reuse the holder in the same cycle it is acked.
      if (frame_done) begin
         if (!dout_valid_q || dout_ack) begin
            dout_d       = full_word;
            dout_valid_d = 1'b1;
         end else begin
            drop = 1'b1;
         end
      end else if (dout_valid_q && dout_ack) begin
         dout_valid_d = 1'b0;
      end else begin
         dout_valid_d = dout_valid_q;
      end

      if (drop) begin
         overflow_d = 1'b1;
      end else if (clr_ovf) begin
         overflow_d = 1'b0;
      end else begin
         overflow_d = overflow_q;
      end
   end

   // State registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_q       <= 2'd0;
         asm_q        <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         slot_q       <= slot_d;
         asm_q        <= asm_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         overflow_q   <= overflow_d;
      end
   end

   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;
   assign slot       = slot_q;
   assign overflow   = overflow_q;

endmodule

// File: tb/tb_demux1_4_capture.sv
// Self-checking bench for demux1_4_capture: directed plan steps followed by
// random traffic against a queue-based frame model.
module tb_demux1_4_capture;

   localparam int DW = 1;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            din_valid = 1'b0;
   logic [DW-1:0]   din = '0;
   logic            din_sof = 1'b0;
   logic [4*DW-1:0] dout;
   logic            dout_valid;
   logic            dout_ack = 1'b0;
   logic [1:0]      slot;
   logic            overflow;
   logic            clr_ovf = 1'b0;

   int checks = 0;
   int errors = 0;

   // Reference model state: beats collected so far in the current frame
   logic [DW-1:0]   part[$];
   logic [4*DW-1:0] m_dout = '0;
   logic            m_valid = 1'b0;
   logic            m_ovf = 1'b0;

   demux1_4_capture #(.DATA_W(DW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .din_valid  (din_valid),
      .din        (din),
`ifdef FRAME_SYNC_EN
      .din_sof    (din_sof),
`endif
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ack   (dout_ack),
      .slot       (slot),
      .overflow   (overflow),
      .clr_ovf    (clr_ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      part.delete();
      m_dout  = '0;
      m_valid = 1'b0;
      m_ovf   = 1'b0;
   endtask

   task automatic model_step();
      logic [4*DW-1:0] w;
      logic done, drop;
      done = 1'b0;
      drop = 1'b0;
      if (din_valid) begin
`ifdef FRAME_SYNC_EN
         if (din_sof) part.delete();
`endif
         part.push_back(din);
         if (part.size() == 4) begin
            for (int k = 0; k < 4; k++) w[k*DW +: DW] = part[k];
            part.delete();
            done = 1'b1;
            if (!m_valid || dout_ack) begin
               m_dout  = w;
               m_valid = 1'b1;
            end else begin
               drop = 1'b1;
            end
         end
      end
      if (!done && m_valid && dout_ack) m_valid = 1'b0;
      if (drop) m_ovf = 1'b1;
      else if (clr_ovf) m_ovf = 1'b0;
   endtask

   task automatic check_model();
      chk("dout", 32'(dout), 32'(m_dout));
      chk("dout_valid", 32'(dout_valid), 32'(m_valid));
      chk("slot", 32'(slot), 32'(part.size()));
      chk("overflow", 32'(overflow), 32'(m_ovf));
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check_model();
   endtask

   task automatic beat(input logic [DW-1:0] b, input logic ack = 1'b0, input logic sof = 1'b0);
      din_valid = 1'b1;
      din       = b;
      dout_ack  = ack;
      din_sof   = sof;
      tick();
      din_valid = 1'b0;
      dout_ack  = 1'b0;
      din_sof   = 1'b0;
   endtask

   task automatic ack_only();
      dout_ack = 1'b1;
      tick();
      dout_ack = 1'b0;
   endtask

   initial begin
      logic [31:0] r;
      model_reset();
      #12;
      chk("reset_dout", 32'(dout), 32'd0);
      chk("reset_valid", 32'(dout_valid), 32'd0);
      chk("reset_slot", 32'(slot), 32'd0);
      chk("reset_ovf", 32'(overflow), 32'd0);
      rst_n = 1'b1;

      // Plan 1: beats 1,0,1,1 -> 4'b1101
      beat(1'b1); beat(1'b0); beat(1'b1); beat(1'b1);
      chk("p1_dout", 32'(dout), 32'h0000_000d);
      chk("p1_valid", 32'(dout_valid), 32'd1);
      chk("p1_slot", 32'(slot), 32'd0);

      // Plan 2: async reset mid-frame, then beats 0,1,1,0 -> 4'b0110
      beat(1'b1); beat(1'b1);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      chk("arst_dout", 32'(dout), 32'd0);
      chk("arst_valid", 32'(dout_valid), 32'd0);
      chk("arst_slot", 32'(slot), 32'd0);
      #1 rst_n = 1'b1;
      beat(1'b0); beat(1'b1); beat(1'b1); beat(1'b0);
      chk("p2_dout", 32'(dout), 32'h0000_0006);

      // Plan 3: A=1010 held, B=0101 dropped, then clear overflow
      ack_only();
      beat(1'b0); beat(1'b1); beat(1'b0); beat(1'b1);
      beat(1'b1); beat(1'b0); beat(1'b1); beat(1'b0);
      chk("p3_dout_kept", 32'(dout), 32'h0000_000a);
      chk("p3_ovf", 32'(overflow), 32'd1);
      clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0;
      chk("p3_ovf_clr", 32'(overflow), 32'd0);

      // Plan 4: ack on the 4th beat of B=0011 -> no bubble
      beat(1'b1); beat(1'b1); beat(1'b0); beat(1'b0, 1'b1);
      chk("p4_dout", 32'(dout), 32'h0000_0003);
      chk("p4_valid", 32'(dout_valid), 32'd1);
      chk("p4_ovf", 32'(overflow), 32'd0);

      // Plan 5: gapped beats 1,1,0,0
      ack_only();
      beat(1'b1); repeat (3) tick();
      chk("p5_slot_hold", 32'(slot), 32'd1);
      beat(1'b1); repeat (3) tick();
      beat(1'b0); repeat (3) tick();
      beat(1'b0);
      chk("p5_dout", 32'(dout), 32'h0000_0003);
      chk("p5_valid", 32'(dout_valid), 32'd1);

      // Plan 6: stream 1,1,(sof)0,1,1,1
      ack_only();
      beat(1'b1); beat(1'b1); beat(1'b0, 1'b0, 1'b1); beat(1'b1); beat(1'b1); beat(1'b1);
`ifdef FRAME_SYNC_EN
      chk("p6_sof_dout", 32'(dout), 32'h0000_000e);
      chk("p6_sof_slot", 32'(slot), 32'd0);
`else
      chk("p6_plain_dout", 32'(dout), 32'h0000_000b);
      chk("p6_plain_slot", 32'(slot), 32'd2);
`endif

      // Random traffic against the model
      for (int i = 0; i < 600; i++) begin
         r = $urandom;
         din_valid = ($urandom_range(0, 3) != 0);
         din       = r[DW-1:0];
         dout_ack  = ($urandom_range(0, 2) == 0);
         clr_ovf   = ($urandom_range(0, 15) == 0);
         din_sof   = ($urandom_range(0, 7) == 0);
         tick();
      end
      din_valid = 1'b0;
      dout_ack  = 1'b0;
      clr_ovf   = 1'b0;
      din_sof   = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/demux1_4_capture.md
Name: demux1_4_capture

Overview:
- Receive-side counterpart of the 4:1 select path: takes a stream of DATA_W-bit beats and steers each into one of four slots.
- Uses an internal 2-bit slot counter in place of an external sel, rebuilding the 4-slot word that the 4:1 mux serialises.
- Completed words sit in a holding register with a valid/ack handshake.
- Sits between a serial or beat-wise source and parallel consumer logic in the lab datapath.

Parameters:
- DATA_W, 1, width of one beat/slot; output word is 4*DATA_W.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- din_valid  input  1  beat present on din this cycle; always accepted.
- din  input  DATA_W  beat data.
- dout  output  4*DATA_W  assembled word; slot k occupies bits [k*DATA_W +: DATA_W].
- dout_valid  output  1  holding register contains an unconsumed word.
- dout_ack  input  1  consumer takes dout; effective only when dout_valid=1.
- slot  output  2  slot index the next accepted beat will fill.
- overflow  output  1  sticky; a completed word was dropped.
- clr_ovf  input  1  synchronous clear of overflow.

Behaviour:
- Reset: one clock (clk); reset rst_n is asynchronous and active-low. While rst_n=0: slot=0, assembly register=0, dout=0, dout_valid=0, overflow=0. Release takes effect at the next clk edge.
- Beat accept: on an edge with din_valid=1, din is written to assembly field [slot], and slot increments modulo 4 (3 -> 0 wrap).
- Frame complete: an accepted beat with slot=3.
  - Full word = assembly slots 0..2 plus the current din as slot 3.
- Holding register load on frame complete, same edge:
  - If dout_valid=0, or dout_ack=1 this cycle: dout <= full word; dout_valid <= 1.
  - Latency: dout/dout_valid visible the cycle after the 4th beat's edge.
  - Else (holder busy, no ack): word dropped; dout unchanged; overflow <= 1.
- Ack without frame complete: dout_valid=1 and dout_ack=1 -> dout_valid <= 0; dout retains its value.
- Ack when dout_valid=0: ignored.
- Simultaneous ack + frame complete: new word loads; dout_valid stays 1, with no bubble.
- Overflow priority:
  - clr_ovf and a new drop in the same cycle -> overflow=1 (set wins).
  - Otherwise clr_ovf -> 0.
- Assembly register is not cleared between frames; stale slots are overwritten by the next frame.
- Reset mid-frame: the partial frame is discarded and slot returns to 0.
- No combinational path from din to dout; all outputs are registered.

Optional Feature:
- Macro: FRAME_SYNC_EN.
- With FRAME_SYNC_EN defined:
  - Extra input din_sof (1 bit).
  - An accepted beat with din_sof=1 is written to slot 0 regardless of the counter, and slot <= 1.
  - Any partial frame in progress is abandoned; no word is emitted for it.
  - din_sof with din_valid=0 is ignored.
  - din_sof on a beat where slot=0 behaves as a normal beat.
- Without FRAME_SYNC_EN: no din_sof port; the slot counter runs free and alignment is set only by reset.

Test Plan:
- Reset, DATA_W=1, beats 1,0,1,1 on consecutive cycles -> one cycle after the 4th edge: dout=4'b1101, dout_valid=1, slot=0, overflow=0.
- Assert rst_n=0 asynchronously mid-cycle after 2 beats -> all outputs 0 immediately. Then beats 0,1,1,0 -> dout=4'b0110.
- Word A=4'b1010 valid, no ack, send word B=4'b0101 -> dout stays 4'b1010, overflow=1. Then clr_ovf=1 for one cycle -> overflow=0.
- Word A valid, dout_ack=1 on the same edge as the 4th beat of B=4'b0011 -> dout=4'b0011, dout_valid remains 1 continuously.
- din_valid gapped (beat, 3 idle cycles, beat, ...) for beats 1,1,0,0 -> slot holds during gaps, and dout=4'b0011 after the 4th beat.
- FRAME_SYNC_EN: beats 1,1 then sof beat 0, then beats 1,1,1 -> first partial frame discarded, dout=4'b1110. A plain build of the same stream without sof -> dout=4'b1011, then the next frame continues from slot 2.
